// File: rtl/conv_window_fetch_if.sv
// conv_window_fetch_if
// Bundles every non-clock signal of conv_window_fetch.
//   en                 run enable
//   addr_r0/1/2_in     row window bases from in_addr_gen
//   ch_end_in          channel-end flag from in_addr_gen
//   addr_inc           advance pulse back to in_addr_gen
//   bram_rd_en         shared read enable for the three BRAM ports
//   bram_addr0/1/2     per-port read address
//   bram_dout0/1/2     per-port read data
//   win_valid/ready    window handshake toward the MAC array
//   win_data           3x3 window, pixel (r,c) at [(3r+c)*DATA_W +: DATA_W]
//   win_ch_start       window starts a new channel
//   busy               fetcher is not idle
// Modport slave is the fetcher's view; master is the view of its surroundings.
interface conv_window_fetch_if #(
  parameter int BRAM_ADDR_BIT = 32,
  parameter int DATA_W        = 8
);
  logic                     en;
  logic [BRAM_ADDR_BIT-1:0] addr_r0_in;
  logic [BRAM_ADDR_BIT-1:0] addr_r1_in;
  logic [BRAM_ADDR_BIT-1:0] addr_r2_in;
  logic                     ch_end_in;
  logic                     addr_inc;
  logic                     bram_rd_en;
  logic [BRAM_ADDR_BIT-1:0] bram_addr0;
  logic [BRAM_ADDR_BIT-1:0] bram_addr1;
  logic [BRAM_ADDR_BIT-1:0] bram_addr2;
  logic [DATA_W-1:0]        bram_dout0;
  logic [DATA_W-1:0]        bram_dout1;
  logic [DATA_W-1:0]        bram_dout2;
  logic                     win_valid;
  logic                     win_ready;
  logic [9*DATA_W-1:0]      win_data;
  logic                     win_ch_start;
  logic                     busy;

  modport slave (
    input  en, addr_r0_in, addr_r1_in, addr_r2_in, ch_end_in,
    input  bram_dout0, bram_dout1, bram_dout2, win_ready,
    output addr_inc, bram_rd_en, bram_addr0, bram_addr1, bram_addr2,
    output win_valid, win_data, win_ch_start, busy
  );

  modport master (
    output en, addr_r0_in, addr_r1_in, addr_r2_in, ch_end_in,
    output bram_dout0, bram_dout1, bram_dout2, win_ready,
    input  addr_inc, bram_rd_en, bram_addr0, bram_addr1, bram_addr2,
    input  win_valid, win_data, win_ch_start, busy
  );
endinterface

// File: rtl/conv_window_fetch.sv
// conv_window_fetch
// Fetches one 3x3 input-feature window per run: latches the three row bases
// from in_addr_gen, reads three columns from three BRAM ports, assembles the
// window and hands it to the MAC array over a valid/ready handshake. The
// accepting handshake is echoed to in_addr_gen as addr_inc.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   conv_window_fetch_if.slave (address, BRAM and window signals)
module conv_window_fetch #(
  parameter int BRAM_ADDR_BIT = 32,
  parameter int DATA_W        = 8,
  parameter int RD_LAT        = 1
) (
  input logic                 clk,
  input logic                 rst,
  conv_window_fetch_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]               state_q;
  logic [1:0]               state_d;
  logic [BRAM_ADDR_BIT-1:0] base_q [3];
  logic [1:0]               col_q;
  logic                     chStart_q;
  logic [9*DATA_W-1:0]      winData_q;
  logic [RD_LAT-1:0]        pipeValid_q;
  logic [1:0]               pipeCol_q [RD_LAT];

  logic [DATA_W-1:0]        dout [3];
  logic                     capValid;
  logic [1:0]               capCol;
  logic                     handshake;

  assign dout[0]   = bus.bram_dout0;
  assign dout[1]   = bus.bram_dout1;
  assign dout[2]   = bus.bram_dout2;

  // The tag at the last pipeline stage lines up with the BRAM data now on dout.
  assign capValid  = pipeValid_q[RD_LAT-1];
  assign capCol    = pipeCol_q[RD_LAT-1];
  assign handshake = (state_q == S_OUT) && bus.win_ready;

  // Next-state logic. WAIT leaves once the last column lands in the window,
  // so OUT starts the cycle after the column-2 capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.en) state_d = S_ISSUE;
      S_ISSUE: if (col_q == 2'd2) state_d = S_WAIT;
      S_WAIT:  if (capValid && capCol == 2'd2) state_d = S_OUT;
      S_OUT:   if (bus.win_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers. Reset also flushes the read-tag pipeline so that
  // reads issued before a reset never land in a later window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      col_q       <= 2'd0;
      chStart_q   <= 1'b0;
      winData_q   <= '0;
      pipeValid_q <= '0;
      for (int r = 0; r < 3; r++) base_q[r] <= '0;
      for (int s = 0; s < RD_LAT; s++) pipeCol_q[s] <= 2'd0;
    end else begin
      state_q <= state_d;

      if (state_q == S_IDLE && bus.en) begin
        base_q[0] <= bus.addr_r0_in;
        base_q[1] <= bus.addr_r1_in;
        base_q[2] <= bus.addr_r2_in;
        chStart_q <= bus.ch_end_in;
        col_q     <= 2'd0;
      end else if (state_q == S_ISSUE) begin
        col_q <= col_q + 2'd1;
      end

      pipeValid_q[0] <= (state_q == S_ISSUE);
      pipeCol_q[0]   <= col_q;
      for (int s = 1; s < RD_LAT; s++) begin
        pipeValid_q[s] <= pipeValid_q[s-1];
        pipeCol_q[s]   <= pipeCol_q[s-1];
      end

      // One column of all three rows is written per returning read.
      if (capValid) begin
        for (int r = 0; r < 3; r++)
          winData_q[(3*r + int'(capCol))*DATA_W +: DATA_W] <= dout[r];
      end
    end
  end

  assign bus.bram_rd_en   = (state_q == S_ISSUE);
  assign bus.bram_addr0   = base_q[0] + BRAM_ADDR_BIT'(col_q);
  assign bus.bram_addr1   = base_q[1] + BRAM_ADDR_BIT'(col_q);
  assign bus.bram_addr2   = base_q[2] + BRAM_ADDR_BIT'(col_q);
  assign bus.win_valid    = (state_q == S_OUT);
  assign bus.addr_inc     = handshake;
  assign bus.win_data     = winData_q;
  assign bus.win_ch_start = chStart_q;
  assign bus.busy         = (state_q != S_IDLE);

endmodule
